// File: rtl/ecnurv_pkg.sv
// ecnurv_pkg: shared definitions for the ECNURVCORE front end.
//   ILEN             - instruction width
//   RESET_PC_DEFAULT - default first fetch address after reset
//   PC_INC           - sequential PC step in bytes
//   if_entry_t       - one buffered fetch result {pc, inst, err}
package ecnurv_pkg;

  localparam int          ILEN             = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam int          PC_INC           = 4;

  typedef struct packed {
    logic [31:0]     pc;
    logic [ILEN-1:0] inst;
    logic            err;
  } if_entry_t;

endpackage

// File: rtl/if_fetch_ibuf.sv
// if_ibuf: DEPTH-entry synchronous FIFO of an arbitrary element type.
// Used both as the fetched-instruction buffer and as the in-flight PC queue.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset (pointers/count only)
//   push, din     - write din at the tail (caller guarantees not full)
//   pop           - drop the head (caller guarantees not empty)
//   clear         - empty the FIFO; takes priority over push/pop
//   dout          - head element (undefined when count == 0)
//   count         - number of stored elements
module if_ibuf
  import ecnurv_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = if_entry_t
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         clear,
  input  T                             din,
  output T                             dout,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  T              mem_q [DEPTH];
  logic [PW-1:0] rd_q;
  logic [PW-1:0] wr_q;
  logic [CW-1:0] cnt_q;

  // Pointer wrap that also works for non-power-of-two depths.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (clear) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= ptr_inc(wr_q);
      if (pop)  rd_q <= ptr_inc(rd_q);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  // Storage carries no reset; validity is tracked by cnt_q alone.
  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_q] <= din;
  end

  assign dout  = mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage. Issues sequential word-aligned fetches on
// an SRAM-style valid/ready bus, keeps up to DEPTH requests in flight or
// buffered, and presents returned instructions in order to IF/ID. A flush
// redirects the PC, empties the buffer and marks all outstanding responses
// for discard.
// Ports:
//   clk, rst                         - clock, asynchronous active-high reset
//   stall_if                         - IF/ID not loading this cycle
//   flush, flush_pc                  - redirect request and target
//   ibus_req_valid/ready/addr        - fetch request channel
//   ibus_rsp_valid/data/err          - in-order response channel
//   if_valid, if_pc, if_inst, if_err - buffer head towards IF/ID
module if_fetch
  import ecnurv_pkg::*;
#(
  parameter int             AW       = 32,
  parameter int             DW       = 32,
  parameter logic [AW-1:0]  RESET_PC = AW'(RESET_PC_DEFAULT),
  parameter int             DEPTH    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall_if,
  input  logic          flush,
  input  logic [AW-1:0] flush_pc,
  output logic          ibus_req_valid,
  input  logic          ibus_req_ready,
  output logic [AW-1:0] ibus_req_addr,
  input  logic          ibus_rsp_valid,
  input  logic [DW-1:0] ibus_rsp_data,
  input  logic          ibus_rsp_err,
  output logic          if_valid,
  output logic [AW-1:0] if_pc,
  output logic [DW-1:0] if_inst,
  output logic          if_err
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0] pc_q, pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_q, drop_d;

  logic [CW-1:0] buf_cnt;
  logic [CW-1:0] pcq_cnt;
  if_entry_t     buf_head;
  if_entry_t     buf_din;
  logic [AW-1:0] pcq_head;

  logic          req_fire;
  logic          rsp_ok;
  logic          pop;
  logic          push_buf;
  logic [CW:0]   credit;

  // A response with nothing outstanding is a bus protocol error; ignore it.
  assign rsp_ok   = ibus_rsp_valid & (inflight_q != '0);
  assign pop      = if_valid & ~stall_if & ~flush;
  assign push_buf = rsp_ok & (drop_q == '0) & ~flush;

  // Live requests plus buffered entries, after this cycle's pop, must leave
  // room for one more result. Responses being dropped do not need space.
  assign credit = {1'b0, inflight_q - drop_q} + {1'b0, buf_cnt}
                - (CW+1)'(pop);

  assign ibus_req_valid = ~rst & ~flush & (inflight_q < CW'(DEPTH))
                        & (credit < (CW+1)'(DEPTH));
  assign ibus_req_addr  = pc_q;
  assign req_fire       = ibus_req_valid & ibus_req_ready;

  always_comb begin
    pc_d       = pc_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    if (flush) begin
      // No request can fire in a flush cycle; everything still outstanding
      // after this edge belongs to the killed stream.
      pc_d       = flush_pc & ~AW'(3);
      inflight_d = inflight_q - CW'(rsp_ok);
      drop_d     = inflight_d;
    end else begin
      if (req_fire) pc_d = pc_q + AW'(PC_INC);
      inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_ok);
      if (rsp_ok && (drop_q != '0)) drop_d = drop_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  // PCs of outstanding requests, consumed in response order.
  if_ibuf #(
    .DEPTH (DEPTH),
    .T     (logic [AW-1:0])
  ) u_pcq (
    .clk   (clk),
    .rst   (rst),
    .push  (req_fire),
    .pop   (rsp_ok),
    .clear (1'b0),
    .din   (pc_q),
    .dout  (pcq_head),
    .count (pcq_cnt)
  );

  assign buf_din = '{pc: 32'(pcq_head), inst: ILEN'(ibus_rsp_data),
                     err: ibus_rsp_err};

  if_ibuf #(
    .DEPTH (DEPTH),
    .T     (if_entry_t)
  ) u_ibuf (
    .clk   (clk),
    .rst   (rst),
    .push  (push_buf),
    .pop   (pop),
    .clear (flush),
    .din   (buf_din),
    .dout  (buf_head),
    .count (buf_cnt)
  );

  // Head fields are forced to zero when empty so stale storage never leaks.
  assign if_valid = (buf_cnt != '0);
  assign if_pc    = if_valid ? AW'(buf_head.pc)   : '0;
  assign if_inst  = if_valid ? DW'(buf_head.inst) : '0;
  assign if_err   = if_valid & buf_head.err;

  a_rsp_needs_inflight: assert property (
    @(posedge clk) disable iff (rst) ibus_rsp_valid |-> (inflight_q != '0));

  a_pcq_matches_inflight: assert property (
    @(posedge clk) disable iff (rst) pcq_cnt == inflight_q);

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the ECNURVCORE pipeline. Generates the sequential PC, issues requests on a valid/ready instruction bus, and tracks up to DEPTH requests in flight. Returned instructions are buffered in order and presented to the IF/ID pipeline register, which loads them when its write enable (`!stall_if`) is high. Branch/jump/exception redirects flush the stage, and responses belonging to the killed stream are discarded.

## Interface
- AW, 32, PC / bus address width
- DW, 32, instruction width
- RESET_PC, 32'h8000_0000, first fetch address after reset
- DEPTH, 2, max in-flight requests plus buffered instructions (≥2)

Ports:
- clk  in  1  single clock; everything is on posedge
- rst  in  1  asynchronous, active-high reset
- stall_if  in  1  IF/ID not loading this cycle
- flush  in  1  redirect from EX
- flush_pc  in  AW  redirect target; bits [1:0] ignored
- ibus_req_valid  out  1  fetch request
- ibus_req_ready  in  1  bus accepts request this cycle
- ibus_req_addr  out  AW  word-aligned fetch address
- ibus_rsp_valid  in  1  response strobe, in request order
- ibus_rsp_data  in  DW  instruction
- ibus_rsp_err  in  1  bus fault for this fetch
- if_valid  out  1  buffer head valid
- if_pc  out  AW  PC of head
- if_inst  out  DW  instruction of head
- if_err  out  1  fault flag of head

## Operation
- State: pc (AW), inflight (0..DEPTH), drop (0..inflight), instruction buffer (DEPTH entries of {pc, inst, err}, count buf_cnt).
- req_fire = ibus_req_valid & ibus_req_ready; rsp_fire = ibus_rsp_valid; pop = if_valid & !stall_if & !flush.
- ibus_req_valid = !rst & !flush & (inflight < DEPTH) & ((inflight - drop) + buf_cnt - pop < DEPTH). This is a credit check that includes a same-cycle pop.
- ibus_req_addr = pc. The bus is SRAM-style: a request exists only in a cycle where valid & ready. Valid/addr may change or drop between cycles without violating the protocol.
- On req_fire: pc <= pc + 4 (wraps modulo 2^AW), and the matching pc is pushed into the in-flight PC queue.
- On rsp_fire with drop == 0: push {queued pc, data, err} into the buffer and decrement inflight.
- On rsp_fire with drop != 0: discard the response and decrement both drop and inflight.
- if_valid = (buf_cnt != 0); if_pc/if_inst/if_err = buffer head.
- On flush:
  - pc <= {flush_pc[AW-1:2], 2'b00}
  - buffer emptied
  - drop <= inflight - rsp_fire
  - inflight <= inflight - rsp_fire
  - any rsp_fire in the flush cycle is discarded
  - no request is issued and no pop occurs
- Simultaneous push and pop: buf_cnt unchanged, and order is preserved.
- Flush while drop is already nonzero: handled correctly, because drop is recomputed from inflight.
- A response arriving when inflight == 0 is a protocol error. The stage ignores it, and an assertion fires.
- if_err does not stop fetching. The exception is raised downstream, which then flushes this stage.

## Timing
- Reset (asynchronous assert, synchronous effect at release):
  - pc = RESET_PC; inflight = drop = buf_cnt = 0
  - ibus_req_valid = 0 while rst = 1
  - if_valid = 0; if_pc, if_inst and if_err are 0
- First request at RESET_PC is valid in the first cycle after rst deasserts.
- Response latency is at least 1 cycle after req_fire; a response never arrives in its own request cycle.
- A response at edge N makes if_valid = 1 from cycle N+1.
- With a 1-cycle memory, no stalls and DEPTH = 2, steady state is one instruction per cycle.
- Flush at edge F:
  - requests to flush_pc can fire from cycle F+1
  - if_valid = 0 from F+1 until the first new response is buffered
- Reset mid-operation clears all state, including drop. The bus must be reset together with this stage.

## Structure
- Shared package `ecnurv_pkg`:
  - ILEN = 32
  - RESET_PC_DEFAULT
  - PC_INC = 4
  - typedef `if_entry_t` {pc, inst, err}
- Sub-module `if_ibuf`: a DEPTH-entry synchronous FIFO of `if_entry_t` with push/pop/clear and count, also reused as the in-flight PC queue.
- The top level holds the pc, inflight and drop counters plus the combinational credit/valid logic.

## Test plan
- Reset release with 1-cycle memory returning addr as data, no stall: requests at 8000_0000, _0004, _0008 on consecutive cycles; if_valid is first high 2 cycles after reset release, then if_pc advances by 4 every cycle.
- Hold stall_if = 1 for 5 cycles: at most DEPTH = 2 requests are issued, ibus_req_valid = 0 afterwards, and the head stays at 8000_0000. On release, one pop per cycle with no loss or duplication.
- Ready held low for 3 cycles: ibus_req_addr stays at the same pc and nothing is pushed. When ready rises, fetch resumes in order.
- 3-cycle memory with 2 requests in flight, flush to 0000_1002: both old responses are discarded and the next request address is 0000_1000. The first if_pc after the flush is 0000_1000.
- Flush in the same cycle as a response, and a second flush while drop = 1: no stale instruction ever appears on if_*, and inflight returns to 0.
- Response with ibus_rsp_err = 1 at pc 8000_0008: if_err = 1 only for that entry, and fetching continues to 8000_000C.
